// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 types, S-box table and round-constant helper
package aes_pkg;

   typedef logic [31:0]  word_t;
   typedef logic [0:127] block_t;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

   // Rcon for rounds 1..10; anything else contributes nothing
   function automatic word_t rcon(input logic [3:0] r);
      logic [7:0] rc;
      case (r)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return {rc, 24'h000000};
   endfunction

endpackage

// File: rtl/aes_subword.sv
// rtl/aes_subword.sv - four parallel S-box lookups on one 32-bit word
module aes_subword
   import aes_pkg::*;
(
   input  logic [31:0] din,
   output logic [31:0] dout
);

   assign dout = {sbox(din[31:24]), sbox(din[23:16]), sbox(din[15:8]), sbox(din[7:0])};

endmodule

// File: rtl/aes_inv_key_sched.sv
// rtl/aes_inv_key_sched.sv - AES-128 reverse key schedule, one round key per handshake
module aes_inv_key_sched
   import aes_pkg::*;
#(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         abort,
   input  logic [0:127] last_key,
   output logic         busy,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [0:127] rk,
   output logic [3:0]   rk_round,
   output logic         done
);

   if (NR != 10) begin : g_nr_check
      $error("aes_inv_key_sched supports only NR = 10");
   end

   typedef enum logic {IDLE, EMIT} state_t;

   state_t state, state_nxt;
   logic   load, step, finish;
   word_t  w0, w1, w2, w3;
   word_t  p0, p1, p2, p3;
   word_t  rot, sub;
   block_t prev_key;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // abort has priority over both start and the consumer handshake
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      rk_valid  = 1'b0;
      load      = 1'b0;
      step      = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               load      = 1'b1;
               state_nxt = EMIT;
            end
         end
         EMIT: begin
            busy     = 1'b1;
            rk_valid = 1'b1;
            if (abort) begin
               state_nxt = IDLE;
            end else if (rk_ready) begin
               if (rk_round == 4'd0) begin
                  finish    = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  step = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign w0 = rk[0:31];
   assign w1 = rk[32:63];
   assign w2 = rk[64:95];
   assign w3 = rk[96:127];

   // p3 is w[4r-1], the word that fed SubWord(RotWord()) when round r was generated
   assign p3  = w3 ^ w2;
   assign p2  = w2 ^ w1;
   assign p1  = w1 ^ w0;
   assign rot = {p3[23:0], p3[31:24]};

   aes_subword u_subword (
      .din  (rot),
      .dout (sub)
   );

   assign p0       = w0 ^ sub ^ rcon(rk_round);
   assign prev_key = {p0, p1, p2, p3};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rk       <= '0;
         rk_round <= 4'd0;
         done     <= 1'b0;
      end else begin
         done <= finish;
         if (load) begin
            rk       <= last_key;
            rk_round <= 4'(NR);
         end else if (step) begin
            rk       <= prev_key;
            rk_round <= rk_round - 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// tb/tb_aes_inv_key_sched.sv - scoreboard bench for the AES-128 reverse key schedule
module tb_aes_inv_key_sched;

   typedef struct packed {
      logic [3:0]   rnd;
      logic [127:0] key;
   } exp_t;

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         start = 1'b0;
   logic         abort = 1'b0;
   logic         rk_ready = 1'b0;
   logic [0:127] last_key = '0;
   logic         busy, rk_valid, done;
   logic [0:127] rk;
   logic [3:0]   rk_round;

   int           checks = 0;
   int           failures = 0;
   exp_t         exp_q[$];
   exp_t         e_mon;
   logic [7:0]   sb [256];
   logic [127:0] rks [11];
   logic         done_due = 1'b0;
   logic         prev_stall = 1'b0;
   logic [0:127] prev_rk = '0;
   logic [3:0]   prev_round = 4'd0;

   aes_inv_key_sched #(.NR(10)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .abort    (abort),
      .last_key (last_key),
      .busy     (busy),
      .rk_valid (rk_valid),
      .rk_ready (rk_ready),
      .rk       (rk),
      .rk_round (rk_round),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00;
      x = a;
      y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = xtime(x);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      logic [15:0] d;
      d = {x, x} << n;
      return d[15:8];
   endfunction

   // S-box from first principles: GF(2^8) inverse followed by the affine map
   function automatic logic [7:0] sbox_calc(input logic [7:0] a);
      logic [7:0] inv;
      inv = 8'h00;
      if (a != 8'h00)
         for (int b = 1; b < 256; b++)
            if (gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
      return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] x);
      return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
   endfunction

   task automatic expand(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
            rc = xtime(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic begin_walk(input logic [127:0] k);
      expand(k);
      for (int r = 10; r >= 0; r--) exp_q.push_back(exp_t'{rnd: 4'(r), key: rks[r]});
      last_key = rks[10];
      rk_ready = 1'b1;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic finish_walk(input bit rnd_ready, input bit chk_lat, input bit poke);
      int n;
      n = 1;
      while (!done && n < 300) begin
         rk_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         start    = (poke && n == 4);
         last_key = (poke && n == 4) ? ~rks[10] : rks[10];
         @(posedge clk); #1;
         n++;
      end
      start    = 1'b0;
      rk_ready = 1'b1;
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL walk_timeout actual=%0d cycles required=done pulse", n);
      end else if (chk_lat) begin
         check("done_latency", 128'(n), 128'd12);
      end
      check("queue_drained", 128'(exp_q.size()), 128'd0);
      exp_q.delete();
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         done_due   = 1'b0;
         prev_stall = 1'b0;
      end else begin
         if (done || done_due) check("done_pulse", 128'(done), 128'(done_due));
         done_due = 1'b0;
         if (prev_stall && rk_valid) begin
            check("stall_rk", rk, prev_rk);
            check("stall_round", 128'(rk_round), 128'(prev_round));
         end
         if (rk_valid && rk_ready && !abort) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_key actual=round %0d required=no key", rk_round);
            end else begin
               e_mon = exp_q.pop_front();
               check("rk_round", 128'(rk_round), 128'(e_mon.rnd));
               check("rk", rk, e_mon.key);
               if (e_mon.rnd == 4'd0) done_due = 1'b1;
            end
         end
         prev_stall = rk_valid && !rk_ready && !abort;
         prev_rk    = rk;
         prev_round = rk_round;
      end
   end

   initial begin
      int n;
      for (int a = 0; a < 256; a++) sb[a] = sbox_calc(8'(a));

      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", 128'(busy), 128'd0);
      check("reset_valid", 128'(rk_valid), 128'd0);
      check("reset_done", 128'(done), 128'd0);
      check("reset_rk", rk, 128'd0);
      check("reset_round", 128'(rk_round), 128'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // FIPS-197 A.1 at full throughput
      begin_walk(FIPS_KEY);
      check("first_valid", 128'(rk_valid), 128'd1);
      check("first_round", 128'(rk_round), 128'd10);
      check("first_key", rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      finish_walk(1'b0, 1'b1, 1'b0);
      check("done_busy", 128'(busy), 128'd0);
      check("done_valid", 128'(rk_valid), 128'd0);
      @(posedge clk); #1;
      check("rk_holds_round0", rk, FIPS_KEY);
      check("done_one_cycle", 128'(done), 128'd0);

      // back-pressure
      for (int i = 0; i < 4; i++) begin
         begin_walk(FIPS_KEY);
         finish_walk(1'b1, 1'b0, 1'b0);
      end

      // round trip through the forward model
      for (int i = 0; i < 1000; i++) begin
         begin_walk({$urandom, $urandom, $urandom, $urandom});
         finish_walk(1'b0, 1'b1, 1'b0);
      end

      // abort during round 5
      begin_walk(FIPS_KEY);
      n = 0;
      while (!(rk_valid && rk_round == 4'd5) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_valid", 128'(rk_valid), 128'd0);
      check("abort_busy", 128'(busy), 128'd0);
      check("abort_rk_hold", rk, rks[5]);
      exp_q.delete();
      repeat (5) @(posedge clk);
      #1;
      check("abort_idle", 128'(rk_valid), 128'd0);
      begin_walk(FIPS_KEY);
      check("restart_round", 128'(rk_round), 128'd10);
      finish_walk(1'b0, 1'b1, 1'b0);

      // start and abort together in IDLE
      @(posedge clk); #1;
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      check("start_abort_idle", 128'(rk_valid), 128'd0);

      // start while busy, then start in the done cycle
      begin_walk(FIPS_KEY);
      finish_walk(1'b0, 1'b1, 1'b1);
      begin_walk(128'h000102030405060708090a0b0c0d0e0f);
      check("done_cycle_start_valid", 128'(rk_valid), 128'd1);
      check("done_cycle_start_round", 128'(rk_round), 128'd10);
      finish_walk(1'b0, 1'b1, 1'b0);

      // asynchronous reset at round 7
      begin_walk(FIPS_KEY);
      n = 0;
      while (!(rk_valid && rk_round == 4'd7) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      #2 rst_n = 1'b0;
      #1;
      check("areset_busy", 128'(busy), 128'd0);
      check("areset_valid", 128'(rk_valid), 128'd0);
      check("areset_done", 128'(done), 128'd0);
      check("areset_round", 128'(rk_round), 128'd0);
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("post_reset_idle", 128'(rk_valid), 128'd0);
      begin_walk(128'hffeeddccbbaa99887766554433221100);
      finish_walk(1'b0, 1'b1, 1'b0);

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
